// File: rtl/ram_ctrl_pkg.sv
// Shared types and default sizing for the RAM load/dump controller.
package ram_ctrl_pkg;

  localparam int unsigned DEF_WORDS  = 128;
  localparam int unsigned DEF_ADDR_W = 7;
  localparam int unsigned DEF_DATA_W = 32;

  // Controller states; IDLE is the only state in which the CPU runs.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RD   = 3'd2,
    ST_CAP  = 3'd3,
    ST_EMIT = 3'd4,
    ST_DONE = 3'd5
  } state_t;

endpackage

// File: rtl/rise_detect.sv
// 1-bit registered rising-edge detector with synchronous reset.
module rise_detect (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_rise
);

  logic r_prev;

  // Previous-cycle copy of the input, updated every cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_d;
    end
  end

  assign o_rise = i_d & ~r_prev;

endmodule

// File: rtl/ram_load_dump_ctrl.sv
// Loads a program image into the datapath RAM on a precharge edge and streams
// the RAM contents back out on a finish edge, holding the CPU while busy.
module ram_load_dump_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned WORDS  = DEF_WORDS,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_precharge,
  input  logic              i_finish,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic              i_load_valid,
  output logic              o_load_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_we,
  output logic              o_mem_re,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [DATA_W-1:0] o_dump_data,
  output logic [ADDR_W-1:0] o_dump_addr,
  output logic              o_dump_valid,
  input  logic              i_dump_ready,
  output logic              o_cpu_hold,
  output logic              o_done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WORDS - 1);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_dump_data;
  logic [ADDR_W-1:0] r_dump_addr;

  logic w_start_load, w_start_dump;
  logic w_accept, w_cnt_last;

  rise_detect u_pc_rise (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_precharge),
    .o_rise  (w_start_load)
  );

  rise_detect u_fin_rise (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_finish),
    .o_rise  (w_start_dump)
  );

  assign w_accept   = (r_state == ST_LOAD) & i_load_valid;
  assign w_cnt_last = (r_cnt == LAST);

  // Next-state and counter logic; load wins over a simultaneous dump edge.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_start_load) begin
          w_state_nxt = ST_LOAD;
          w_cnt_nxt   = '0;
        end else if (w_start_dump) begin
          w_state_nxt = ST_RD;
          w_cnt_nxt   = '0;
        end
      end
      ST_LOAD: begin
        if (w_accept) begin
          if (w_cnt_last) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      ST_RD:   w_state_nxt = ST_CAP;
      ST_CAP:  w_state_nxt = ST_EMIT;
      ST_EMIT: begin
        if (i_dump_ready) begin
          if (w_cnt_last) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_cnt_nxt   = r_cnt + 1'b1;
            w_state_nxt = ST_RD;
          end
        end
      end
      ST_DONE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Combinational outputs; everything idles at zero outside its active state.
  always_comb begin
    o_load_ready = (r_state == ST_LOAD);
    o_mem_we     = w_accept;
    o_mem_wdata  = w_accept ? i_load_data : '0;
    o_mem_re     = (r_state == ST_RD);
    o_mem_addr   = (w_accept || (r_state == ST_RD)) ? r_cnt : '0;
    o_dump_valid = (r_state == ST_EMIT);
    o_dump_data  = r_dump_data;
    o_dump_addr  = r_dump_addr;
    o_cpu_hold   = (r_state != ST_IDLE);
    o_done       = (r_state == ST_DONE);
  end

  // State, counter and dump-word registers; RAM data is captured in CAP.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_dump_data <= '0;
      r_dump_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (r_state == ST_CAP) begin
        r_dump_data <= i_mem_rdata;
        r_dump_addr <= r_cnt;
      end
    end
  end

endmodule

// File: tb/tb_ram_load_dump_ctrl.sv
// Scoreboard bench: directed stimulus pushes expected RAM writes and dump words
// into queues; a negedge monitor pops and compares them as the DUT emits them.
module tb_ram_load_dump_ctrl;

  localparam int unsigned WORDS  = 4;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset, precharge, finish;
  logic [DATA_W-1:0] load_data;
  logic              load_valid, load_ready;
  logic [ADDR_W-1:0] mem_addr, dump_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata, dump_data;
  logic              mem_we, mem_re, dump_valid, dump_ready, cpu_hold, done;

  int n_chk = 0;
  int n_fail = 0;
  int re_cnt = 0;
  int done_cnt = 0;

  logic [ADDR_W-1:0] exp_wa[$];
  logic [DATA_W-1:0] exp_wd[$];
  logic [ADDR_W-1:0] exp_da[$];
  logic [DATA_W-1:0] exp_dd[$];

  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] wa [0:3];
  logic [DATA_W-1:0] wc [0:3];
  logic [ADDR_W-1:0] m_a;
  logic [DATA_W-1:0] m_d;

  always #5 clk = ~clk;

  ram_load_dump_ctrl #(
    .WORDS  (WORDS),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_precharge  (precharge),
    .i_finish     (finish),
    .i_load_data  (load_data),
    .i_load_valid (load_valid),
    .o_load_ready (load_ready),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .o_mem_we     (mem_we),
    .o_mem_re     (mem_re),
    .i_mem_rdata  (mem_rdata),
    .o_dump_data  (dump_data),
    .o_dump_addr  (dump_addr),
    .o_dump_valid (dump_valid),
    .i_dump_ready (dump_ready),
    .o_cpu_hold   (cpu_hold),
    .o_done       (done)
  );

  // Datapath RAM: single-cycle write, read data one cycle after mem_re.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Monitor: pop and compare whenever the DUT writes RAM or hands off a dump word.
  always @(negedge clk) begin
    if (mem_re) re_cnt++;
    if (done) done_cnt++;
    if (mem_we) begin
      if (exp_wa.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %h, expected none", mem_addr, mem_wdata);
      end else begin
        m_a = exp_wa.pop_front();
        m_d = exp_wd.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(m_a));
        chk("wr_data", mem_wdata, m_d);
      end
    end
    if (dump_valid && dump_ready) begin
      if (exp_da.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_dump: got addr %0d data %h, expected none", dump_addr, dump_data);
      end else begin
        m_a = exp_da.pop_front();
        m_d = exp_dd.pop_front();
        chk("dump_addr", 32'(dump_addr), 32'(m_a));
        chk("dump_data", dump_data, m_d);
      end
    end
  end

  task automatic push_writes(input logic [DATA_W-1:0] w0, w1, w2, w3);
    exp_wa.push_back(0); exp_wd.push_back(w0);
    exp_wa.push_back(1); exp_wd.push_back(w1);
    exp_wa.push_back(2); exp_wd.push_back(w2);
    exp_wa.push_back(3); exp_wd.push_back(w3);
  endtask

  task automatic push_dumps(input logic [DATA_W-1:0] w0, w1, w2, w3);
    exp_da.push_back(0); exp_dd.push_back(w0);
    exp_da.push_back(1); exp_dd.push_back(w1);
    exp_da.push_back(2); exp_dd.push_back(w2);
    exp_da.push_back(3); exp_dd.push_back(w3);
  endtask

  // Dump from a finish edge; optional stall of dump_ready starting at cycle stall_c.
  task automatic do_dump(input int stall_c, input int stall_len, input logic [31:0] stall_data,
                         input int exp_done_c);
    int  re0;
    int  hs;
    bit  got;
    bit  first;
    re0 = re_cnt; hs = 0; got = 0; first = 0;
    finish = 1'b1;
    dump_ready = 1'b1;
    sample();
    for (int c = 1; c <= 60 && !got; c++) begin
      tick();
      dump_ready = !(c >= stall_c && c < stall_c + stall_len);
      sample();
      if (c == 1) begin
        chk("rd_mem_re", 32'(mem_re), 1);
        chk("rd_mem_addr", 32'(mem_addr), 0);
      end
      if (dump_valid && !first) begin
        first = 1;
        chk("first_valid_cyc", c, 3);
      end
      if (dump_valid && dump_ready) begin
        if (stall_len == 0) chk("word_cyc", c, 3 * (hs + 1));
        hs++;
      end
      if (c >= stall_c && c < stall_c + stall_len) begin
        chk("stall_valid", 32'(dump_valid), 1);
        chk("stall_data", dump_data, stall_data);
        chk("stall_addr", 32'(dump_addr), 2);
      end
      if (done) begin
        got = 1;
        chk("dump_done_cyc", c, exp_done_c);
      end
    end
    if (!got) chk("dump_timeout", 0, 1);
    tick();
    finish = 1'b0;
    dump_ready = 1'b1;
    chk("dump_re_count", re_cnt - re0, WORDS);
    chk("dump_hs_count", hs, WORDS);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    wa[0] = 32'hA0000001; wa[1] = 32'hA0000002; wa[2] = 32'hA0000003; wa[3] = 32'hA0000004;
    wc[0] = 32'hC0000001; wc[1] = 32'hC0000002; wc[2] = 32'hC0000003; wc[3] = 32'hC0000004;
    reset = 1'b1; precharge = 1'b0; finish = 1'b0;
    load_data = '0; load_valid = 1'b0; dump_ready = 1'b1;
    repeat (3) tick();
    sample();
    chk("rst_cpu_hold", 32'(cpu_hold), 0);
    chk("rst_load_ready", 32'(load_ready), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_re", 32'(mem_re), 0);
    chk("rst_dump_valid", 32'(dump_valid), 0);
    chk("rst_dump_data", dump_data, 0);
    chk("rst_done", 32'(done), 0);
    tick();
    reset = 1'b0;
    tick();

    // Back-to-back load of four words.
    push_writes(wa[0], wa[1], wa[2], wa[3]);
    precharge = 1'b1; load_valid = 1'b1; load_data = wa[0];
    sample();
    chk("edge_cpu_hold", 32'(cpu_hold), 0);
    chk("edge_load_ready", 32'(load_ready), 0);
    tick();
    sample();
    chk("load_cpu_hold", 32'(cpu_hold), 1);
    chk("load_ready", 32'(load_ready), 1);
    chk("load_we0", 32'(mem_we), 1);
    for (int i = 1; i < 4; i++) begin
      tick();
      load_data = wa[i];
      sample();
      chk("load_we", 32'(mem_we), 1);
    end
    tick();
    load_valid = 1'b0;
    sample();
    chk("load_done", 32'(done), 1);
    chk("done_cpu_hold", 32'(cpu_hold), 1);
    tick();
    sample();
    chk("post_done_hold", 32'(cpu_hold), 0);
    chk("post_done_pulse", 32'(done), 0);
    repeat (2) tick();
    sample();
    chk("held_pc_no_retrigger", 32'(cpu_hold), 0);
    chk("load1_done_count", done_cnt, 1);
    chk("load1_queue_empty", exp_wa.size(), 0);
    precharge = 1'b0;
    tick();

    // Stalled load: valid every other cycle.
    push_writes(wa[0], wa[1], wa[2], wa[3]);
    precharge = 1'b1;
    tick();
    for (int k = 0; k < 7; k++) begin
      load_valid = (k % 2 == 0);
      load_data = (k % 2 == 0) ? wa[k/2] : 32'hDEADBEEF;
      sample();
      if (k % 2 != 0) chk("stall_no_we", 32'(mem_we), 0);
      if (k == 5) chk("stall_no_early_done", 32'(done), 0);
      tick();
    end
    load_valid = 1'b0;
    sample();
    chk("stall_load_done", 32'(done), 1);
    tick();
    precharge = 1'b0;
    chk("load2_done_count", done_cnt, 2);
    chk("load2_queue_empty", exp_wa.size(), 0);
    tick();

    // Dump with ready tied high, then with a five-cycle stall on word 2.
    push_dumps(wa[0], wa[1], wa[2], wa[3]);
    do_dump(100, 0, 0, 13);
    tick();
    push_dumps(wa[0], wa[1], wa[2], wa[3]);
    do_dump(9, 5, wa[2], 18);
    chk("dump_done_count", done_cnt, 4);
    tick();

    // Simultaneous edges: load wins; a finish edge during LOAD is dropped.
    push_writes(wc[0], wc[1], wc[2], wc[3]);
    d0 = re_cnt;
    precharge = 1'b1; finish = 1'b1; load_valid = 1'b1; load_data = wc[0];
    sample();
    tick();
    finish = 1'b0;
    sample();
    chk("both_edges_load", 32'(load_ready), 1);
    for (int i = 1; i < 4; i++) begin
      tick();
      load_data = wc[i];
      if (i == 2) finish = 1'b1;
    end
    tick();
    load_valid = 1'b0;
    sample();
    chk("both_load_done", 32'(done), 1);
    repeat (3) begin
      tick();
      sample();
      chk("no_dump_hold", 32'(cpu_hold), 0);
    end
    chk("no_dump_re", re_cnt - d0, 0);
    finish = 1'b0; precharge = 1'b0;
    tick();
    push_dumps(wc[0], wc[1], wc[2], wc[3]);
    do_dump(100, 0, 0, 13);
    tick();

    // Reset at word 1 of a dump, then a fresh dump restarts from address 0.
    exp_da.push_back(0); exp_dd.push_back(wc[0]);
    finish = 1'b1;
    sample();
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 6) begin
        dump_ready = 1'b0;
        reset = 1'b1;
        finish = 1'b0;
      end
      sample();
    end
    chk("pre_rst_valid", 32'(dump_valid), 1);
    chk("pre_rst_addr", 32'(dump_addr), 1);
    tick();
    reset = 1'b0;
    dump_ready = 1'b1;
    sample();
    chk("mid_rst_cpu_hold", 32'(cpu_hold), 0);
    chk("mid_rst_dump_valid", 32'(dump_valid), 0);
    chk("mid_rst_dump_data", dump_data, 0);
    chk("mid_rst_dump_addr", 32'(dump_addr), 0);
    chk("mid_rst_mem_addr", 32'(mem_addr), 0);
    chk("mid_rst_mem_re", 32'(mem_re), 0);
    chk("mid_rst_done", 32'(done), 0);
    tick();
    push_dumps(wc[0], wc[1], wc[2], wc[3]);
    do_dump(100, 0, 0, 13);
    repeat (2) tick();

    chk("final_wr_queue", exp_wa.size(), 0);
    chk("final_dump_queue", exp_da.size(), 0);
    chk("final_done_count", done_cnt, 7);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
